// File: rtl/case_2_sdiv_pkg.sv
// Shared types, widths and helpers for the sequential signed divider.
package case_2_sdiv_pkg;

   // Default operand widths of the 26s / 12s divider.
   localparam int DIN0_W     = 26;
   localparam int DIN1_W     = 12;

   // Iteration counter width; it counts dividend bits from DIN0_W-1 down to 0.
   localparam int CNT_WIDTH  = $clog2(DIN0_W);

   // Partial remainder carries one bit more than the divisor, so a magnitude of
   // 2^(DIN1_W-1) still fits.
   localparam int REM_WIDTH  = DIN1_W + 1;

   // Widest magnitude the helper below handles (dividend plus one bit).
   localparam int ABS_W      = DIN0_W + 1;

   // Controller states.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Magnitude of a sign-extended two's complement value. The argument is one bit
   // wider than the operand it came from, so the most negative operand maps onto
   // its true magnitude instead of wrapping.
   function automatic logic [ABS_W-1:0] abs_ext(input logic [ABS_W-1:0] x);
      logic [ABS_W-1:0] mag;
      if (x[ABS_W-1] == 1'b1) begin
         mag = {ABS_W{1'b0}} - x;
      end else begin
         mag = x;
      end
      return mag;
   endfunction

endpackage

// File: rtl/case_2_sdiv_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to
// subtract the divisor magnitude, and keep the difference only if it is not negative.
module case_2_sdiv_step
   import case_2_sdiv_pkg::*;
#(
   parameter int REM_W = REM_WIDTH
)(
   input  logic [REM_W-1:0] i_rem,
   input  logic             i_bit,
   input  logic [REM_W-1:0] i_dvs,
   output logic [REM_W-1:0] o_rem,
   output logic             o_qbit
);

   logic [REM_W:0] w_shift;
   logic [REM_W:0] w_dvs_ext;

   // Trial subtraction; with a zero divisor every trial succeeds and the shifted
   // value is kept, truncated to the partial remainder width.
   always_comb begin
      w_shift   = {i_rem, i_bit};
      w_dvs_ext = {1'b0, i_dvs};
      if (w_shift >= w_dvs_ext) begin
         o_qbit = 1'b1;
         o_rem  = REM_W'(w_shift - w_dvs_ext);
      end else begin
         o_qbit = 1'b0;
         o_rem  = REM_W'(w_shift);
      end
   end

endmodule

// File: rtl/case_2_sdiv_26s_12s_seq.sv
// Sequential signed divider (26-bit dividend / 12-bit divisor), radix-2 restoring,
// one quotient bit per enabled clock, C truncating semantics, start/done handshake.
module case_2_sdiv_26s_12s_seq
   import case_2_sdiv_pkg::*;
#(
   parameter int ID         = 1,
   parameter int din0_WIDTH = DIN0_W,
   parameter int din1_WIDTH = DIN1_W,
   parameter int dout_WIDTH = DIN0_W
)(
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ce,
   input  logic                  start,
   output logic                  ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  done,
   output logic [dout_WIDTH-1:0] quot,
   output logic [din1_WIDTH-1:0] remd,
   output logic                  div0
);

   localparam int CNT_W = $clog2(din0_WIDTH);
   localparam int REM_W = din1_WIDTH + 1;
   localparam int DVD_W = din0_WIDTH + 1;

   // The quotient register doubles as the dividend-width result, and the
   // magnitude helper is sized for the default dividend width.
   if ((dout_WIDTH != din0_WIDTH) || (DVD_W > ABS_W) || (REM_W > ABS_W) || (ID < 0)) begin : g_param_check
      $error("case_2_sdiv_26s_12s_seq: unsupported parameter set");
   end

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DVD_W-1:0]      r_dvd;
   logic [REM_W-1:0]      r_dvs;
   logic [REM_W-1:0]      r_rem;
   logic [dout_WIDTH-1:0] r_q;
   logic                  r_sign_q;
   logic                  r_sign_r;
   logic                  r_dz;

   logic                  w_bit;
   logic [REM_W-1:0]      w_rem;
   logic                  w_qbit;

   // Dividend magnitude bits are consumed MSB first, selected by the counter.
   assign w_bit = r_dvd[r_cnt];

   case_2_sdiv_step #(
      .REM_W (REM_W)
   ) u_step (
      .i_rem  (r_rem),
      .i_bit  (w_bit),
      .i_dvs  (r_dvs),
      .o_rem  (w_rem),
      .o_qbit (w_qbit)
   );

   // Controller, iteration datapath and registered result/handshake outputs.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= {CNT_W{1'b0}};
         r_dvd    <= {DVD_W{1'b0}};
         r_dvs    <= {REM_W{1'b0}};
         r_rem    <= {REM_W{1'b0}};
         r_q      <= {dout_WIDTH{1'b0}};
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_dz     <= 1'b0;
         ready    <= 1'b1;
         done     <= 1'b0;
         quot     <= {dout_WIDTH{1'b0}};
         remd     <= {din1_WIDTH{1'b0}};
         div0     <= 1'b0;
      end else if (ce) begin
         // The done pulse lasts until the next enabled edge.
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && ready) begin
                  r_dvd    <= DVD_W'(abs_ext(ABS_W'($signed(din0))));
                  r_dvs    <= REM_W'(abs_ext(ABS_W'($signed(din1))));
                  r_sign_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                  r_sign_r <= din0[din0_WIDTH-1];
                  r_dz     <= (din1 == {din1_WIDTH{1'b0}});
                  r_rem    <= {REM_W{1'b0}};
                  r_q      <= {dout_WIDTH{1'b0}};
                  r_cnt    <= CNT_W'(din0_WIDTH - 1);
                  ready    <= 1'b0;
                  r_state  <= S_CALC;
               end
            end
            S_CALC: begin
               r_rem <= w_rem;
               r_q   <= {r_q[dout_WIDTH-2:0], w_qbit};
               if (r_cnt == {CNT_W{1'b0}}) begin
                  r_state <= S_FIX;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_FIX: begin
               // |R| < |divisor| <= 2^(din1_WIDTH-1), so the low bits carry R exactly;
               // for a zero divisor they are the truncated dividend magnitude.
               quot    <= r_sign_q ? ({dout_WIDTH{1'b0}} - r_q) : r_q;
               remd    <= r_sign_r ? ({din1_WIDTH{1'b0}} - r_rem[din1_WIDTH-1:0])
                                   : r_rem[din1_WIDTH-1:0];
               div0    <= r_dz;
               r_state <= S_DONE;
            end
            S_DONE: begin
               done    <= 1'b1;
               ready   <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               ready   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_case_2_sdiv_26s_12s_seq.sv
// Self-checking bench for the sequential signed divider: directed corner cases,
// reset/stall/busy scenarios and back-to-back random operations against a C-style model.
module tb_case_2_sdiv_26s_12s_seq;

   logic        ap_clk;
   logic        ap_rst_n;
   logic        ce;
   logic        start;
   logic        ready;
   logic [25:0] din0;
   logic [11:0] din1;
   logic        done;
   logic [25:0] quot;
   logic [11:0] remd;
   logic        div0;

   int n_pass;
   int n_total;

   case_2_sdiv_26s_12s_seq dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .ce       (ce),
      .start    (start),
      .ready    (ready),
      .din0     (din0),
      .din1     (din1),
      .done     (done),
      .quot     (quot),
      .remd     (remd),
      .div0     (div0)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // C division semantics: truncate toward zero, remainder follows the dividend.
   task automatic model(input int a, input int b, output logic [25:0] q,
                        output logic [11:0] r, output logic z);
      longint la;
      longint lb;
      la = a;
      lb = b;
      if (lb == 0) begin
         z = 1'b1;
         q = (la < 0) ? 26'd1 : 26'h3FF_FFFF;
         r = a[11:0];
      end else begin
         z = 1'b0;
         q = 26'(la / lb);
         r = 12'(la % lb);
      end
   endtask

   // Issue one operation from a negedge with ready high and follow it to done.
   task automatic run_op(input int a, input int b, input int pulse_at,
                         input int stall_at, input int stall_len, input int done_stall);
      logic [25:0] exp_q;
      logic [11:0] exp_r;
      logic        exp_z;
      int          j;
      int          cyc;
      int          stall_left;
      logic        seen;
      logic        rdy_bad;
      model(a, b, exp_q, exp_r, exp_z);
      din0  = 26'(a);
      din1  = 12'(b);
      start = 1'b1;
      ce    = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      start      = 1'b0;
      j          = 0;
      cyc        = 0;
      seen       = 1'b0;
      rdy_bad    = 1'b0;
      stall_left = stall_len;
      for (int t = 0; t < 100; t++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (ready !== 1'b0) rdy_bad = 1'b1;
         if (j == stall_at && stall_left > 0) begin
            ce = 1'b0;
            stall_left--;
         end else begin
            ce = 1'b1;
         end
         if (pulse_at >= 0 && (j == pulse_at || j == pulse_at + 12)) begin
            start = 1'b1;
            din0  = 26'($urandom);
            din1  = 12'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge ap_clk);
         if (ce) j++;
         cyc++;
         @(negedge ap_clk);
      end
      ce    = 1'b1;
      start = 1'b0;
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency_ce_edges", j, 28);
      chk("latency_cycles", cyc, 28 + stall_len);
      chk("ready_low_busy", 32'(rdy_bad), 32'd0);
      chk("quot", 32'(quot), 32'(exp_q));
      chk("remd", 32'(remd), 32'(exp_r));
      chk("div0", 32'(div0), 32'(exp_z));
      if (done_stall > 0) begin
         for (int d = 0; d < done_stall; d++) begin
            ce = 1'b0;
            @(posedge ap_clk);
            @(negedge ap_clk);
            chk("done_held_in_stall", 32'(done), 32'd1);
            chk("quot_held_in_stall", 32'(quot), 32'(exp_q));
         end
         ce = 1'b1;
         @(posedge ap_clk);
         @(negedge ap_clk);
         chk("done_drop_after_stall", 32'(done), 32'd0);
      end
   endtask

   initial begin
      logic signed [25:0] ra;
      logic signed [11:0] rb;
      int                 sel;
      logic               nd;
      n_pass   = 0;
      n_total  = 0;
      ap_rst_n = 1'b0;
      ce       = 1'b0;
      start    = 1'b0;
      din0     = 26'd0;
      din1     = 12'd0;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quot", 32'(quot), 32'd0);
      chk("rst_remd", 32'(remd), 32'd0);
      chk("rst_div0", 32'(div0), 32'd0);
      ap_rst_n = 1'b1;
      ce       = 1'b1;
      @(negedge ap_clk);

      // Sign combinations and edge operands.
      run_op(100, 7, -1, -1, 0, 0);
      run_op(-100, 7, -1, -1, 0, 0);
      run_op(100, -7, -1, -1, 0, 0);
      run_op(-100, -7, -1, -1, 0, 0);
      run_op(-33554432, -1, -1, -1, 0, 0);
      run_op(33554431, -2048, -1, -1, 0, 0);
      run_op(-33554432, -2048, -1, -1, 0, 0);
      run_op(5, 0, -1, -1, 0, 0);
      run_op(-5, 0, -1, -1, 0, 0);

      // Reset in the middle of an operation.
      din0  = 26'd1000;
      din1  = 12'd3;
      start = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      start = 1'b0;
      repeat (9) @(negedge ap_clk);
      ap_rst_n = 1'b0;
      @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      chk("midrst_ready", 32'(ready), 32'd1);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_quot", 32'(quot), 32'd0);
      chk("midrst_remd", 32'(remd), 32'd0);
      chk("midrst_div0", 32'(div0), 32'd0);
      nd = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge ap_clk);
         if (done !== 1'b0) nd = 1'b1;
      end
      chk("no_done_after_reset", 32'(nd), 32'd0);
      run_op(9, 2, -1, -1, 0, 0);

      // Start pulses while busy, then clock-enable stalls in CALC and DONE.
      run_op(1000, 3, 5, -1, 0, 0);
      run_op(-12345, 77, -1, 10, 5, 2);
      run_op(777, -13, 3, 20, 5, 2);

      // Back-to-back random operations.
      for (int n = 0; n < 1500; n++) begin
         sel = $urandom_range(0, 9);
         ra  = 26'($urandom);
         if (sel == 0) ra = 26'h200_0000;
         if (sel == 1) ra = 26'h1FF_FFFF;
         sel = $urandom_range(0, 9);
         rb  = 12'($urandom);
         if (sel == 0) rb = 12'd0;
         if (sel >= 1 && sel <= 3) rb = 12'($urandom_range(0, 15)) - 12'd8;
         run_op(int'(ra), int'(rb), -1, -1, 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
